// File: rtl/belt_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : belt_pkg
// Description : Shared helpers for the multi-port belt: clog2, position type,
//               prefix-count used to map drop slots onto write offsets.
// Revision    : 1.0 - initial release
// ============================================================================
package belt_pkg;

    // Upper bound on DROPS supported by the prefix-count helper.
    localparam int MAX_DROPS = 64;
    localparam int DEF_DEPTH = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    typedef logic [clog2(DEF_DEPTH)-1:0] belt_pos_t;

    // Number of set bits in vec[upto-1:0]; upto = width gives the popcount.
    function automatic int prefix_count(input logic [MAX_DROPS-1:0] vec, input int upto);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_DROPS; i++) begin
            if ((i < upto) && vec[i]) begin
                cnt++;
            end
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/belt_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : belt_mp_if
// Description : Drop / read / occupancy bundle between pipeline and belt.
// Revision    : 1.0 - initial release
// ============================================================================
interface belt_mp_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int RPORTS = 2,
    parameter int DROPS  = 2
);
    import belt_pkg::*;

    localparam int PW = clog2(DEPTH);

    logic                      clear;
    logic [DROPS-1:0]          drop_valid;
    logic [DROPS*WIDTH-1:0]    drop_data;
    logic [RPORTS-1:0]         rd_en;
    logic [RPORTS*PW-1:0]      rd_pos;
    logic [RPORTS*WIDTH-1:0]   rd_data;
    logic [RPORTS-1:0]         rd_vld;
    logic [PW:0]               occ;

    modport master (
        output clear, drop_valid, drop_data, rd_en, rd_pos,
        input  rd_data, rd_vld, occ
    );

    modport slave (
        input  clear, drop_valid, drop_data, rd_en, rd_pos,
        output rd_data, rd_vld, occ
    );

endinterface
`default_nettype wire

// File: rtl/belt_mp_rport.sv
`default_nettype none
// ============================================================================
// Module      : belt_rport
// Description : One belt read port: position->address, valid compare,
//               optional same-edge forwarding and the output register.
// Revision    : 1.0 - initial release
// ============================================================================
module belt_rport
    import belt_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int BYPASS = 0,
    localparam int PW    = clog2(DEPTH)
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rd_en,
    input  logic [PW-1:0]               rd_pos,
    input  logic [DEPTH-1:0][WIDTH-1:0] mem,
    input  logic [DEPTH-1:0][WIDTH-1:0] view,
    input  logic [PW-1:0]               idx,
    input  logic [PW-1:0]               idx_nxt,
    input  logic [PW:0]                 occ,
    input  logic [PW:0]                 occ_nxt,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        rd_vld
);

    logic [PW-1:0]               w_idx_v;
    logic [PW-1:0]               w_addr;
    logic [PW:0]                 w_occ_v;
    logic [DEPTH-1:0][WIDTH-1:0] w_arr;
    logic                        w_hit;
    logic [WIDTH-1:0]            w_data;

    // With forwarding, the post-edge view already merges this cycle's drops.
    always_comb begin
        w_idx_v = (BYPASS != 0) ? idx_nxt : idx;
        w_occ_v = (BYPASS != 0) ? occ_nxt : occ;
        w_arr   = (BYPASS != 0) ? view    : mem;
        w_addr  = w_idx_v - PW'(1) - rd_pos;
        w_hit   = ({1'b0, rd_pos} < w_occ_v);
        w_data  = w_hit ? w_arr[w_addr] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else if (rd_en) begin
            rd_data <= w_data;
            rd_vld  <= w_hit;
        end
    end

endmodule
`default_nettype wire

// File: rtl/belt_mp.sv
`default_nettype none
// ============================================================================
// Module      : belt_mp
// Description : Parametrised multi-port belt with occupancy tracking and clear.
// Revision    : 1.0 - initial release
// ============================================================================
module belt_mp
    import belt_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int RPORTS = 2,
    parameter int DROPS  = 2,
    parameter int BYPASS = 0
)(
    input  logic      clk,
    input  logic      rst_n,
    belt_mp_if.slave  bus
);

    localparam int PW = clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [DEPTH-1:0][WIDTH-1:0] w_view;
    logic [PW-1:0]               r_idx;
    logic [PW-1:0]               w_idx_nxt;
    logic [PW:0]                 r_occ;
    logic [PW:0]                 w_occ_nxt;
    logic [PW:0]                 w_occ_base;
    logic [PW:0]                 w_cnt;
    logic [PW+1:0]               w_occ_sum;
    logic [PW-1:0]               w_off [DROPS];
    logic [MAX_DROPS-1:0]        w_dv_ext;
    logic [RPORTS-1:0]           w_rd_en;
    logic [RPORTS*PW-1:0]        w_rd_pos;
    logic [RPORTS*WIDTH-1:0]     w_rd_data;
    logic [RPORTS-1:0]           w_rd_vld;

    assign w_dv_ext = MAX_DROPS'(bus.drop_valid);
    assign w_rd_en  = bus.rd_en;
    assign w_rd_pos = bus.rd_pos;

    // Each valid slot writes at idx plus the number of valid slots below it.
    generate
        for (genvar k = 0; k < DROPS; k++) begin : g_off
            assign w_off[k] = PW'(prefix_count(w_dv_ext, k));
        end
    endgenerate

    assign w_cnt = (PW+1)'(prefix_count(w_dv_ext, DROPS));

    always_comb begin
        w_view = r_mem;
        for (int k = 0; k < DROPS; k++) begin
            if (bus.drop_valid[k]) begin
                w_view[r_idx + w_off[k]] = bus.drop_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Storage is deliberately unreset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        r_mem <= w_view;
    end

    // Clear takes effect before this cycle's drops are counted in.
    assign w_idx_nxt  = r_idx + w_cnt[PW-1:0];
    assign w_occ_base = bus.clear ? '0 : r_occ;
    assign w_occ_sum  = {1'b0, w_occ_base} + {1'b0, w_cnt};
    assign w_occ_nxt  = (w_occ_sum > (PW+2)'(DEPTH)) ? (PW+1)'(DEPTH) : w_occ_sum[PW:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_occ <= '0;
        end else begin
            r_idx <= w_idx_nxt;
            r_occ <= w_occ_nxt;
        end
    end

    generate
        for (genvar p = 0; p < RPORTS; p++) begin : g_rport
            belt_rport #(
                .WIDTH  (WIDTH),
                .DEPTH  (DEPTH),
                .BYPASS (BYPASS)
            ) u_rport (
                .clk     (clk),
                .rst_n   (rst_n),
                .rd_en   (w_rd_en[p]),
                .rd_pos  (w_rd_pos[p*PW +: PW]),
                .mem     (r_mem),
                .view    (w_view),
                .idx     (r_idx),
                .idx_nxt (w_idx_nxt),
                .occ     (r_occ),
                .occ_nxt (w_occ_nxt),
                .rd_data (w_rd_data[p*WIDTH +: WIDTH]),
                .rd_vld  (w_rd_vld[p])
            );
        end
    endgenerate

    assign bus.rd_data = w_rd_data;
    assign bus.rd_vld  = w_rd_vld;
    assign bus.occ     = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_belt_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_belt_mp
// Description : Self-checking bench for belt_mp, BYPASS=0 and BYPASS=1 side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_belt_mp;

    localparam int c_width = 32;
    localparam int c_depth = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    belt_mp_if #(.WIDTH(c_width), .DEPTH(c_depth), .RPORTS(2), .DROPS(2)) b0 ();
    belt_mp_if #(.WIDTH(c_width), .DEPTH(c_depth), .RPORTS(2), .DROPS(2)) b1 ();

    belt_mp #(.WIDTH(c_width), .DEPTH(c_depth), .RPORTS(2), .DROPS(2), .BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave));
    belt_mp #(.WIDTH(c_width), .DEPTH(c_depth), .RPORTS(2), .DROPS(2), .BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));

    int checks   = 0;
    int failures = 0;

    // Reference belt: element 0 is the most recent drop.
    logic [31:0] model_q [$];
    logic [31:0] e0d [2];
    logic        e0v [2];
    logic [31:0] e1d [2];
    logic        e1v [2];

    typedef struct {
        logic        clr;
        logic [1:0]  dv;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  ren;
        int          p0;
        int          p1;
        int          eocc;
        logic [31:0] ed0;
        logic        ev0;
        logic [31:0] ed1;
        logic        ev1;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] model_read(input int pos);
        if (pos < model_q.size()) return {1'b1, model_q[pos]};
        return 33'h0;
    endfunction

    task automatic drive(input logic clr, input logic [1:0] dv, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [1:0] ren, input int p0, input int p1);
        b0.clear = clr;  b0.drop_valid = dv;  b0.drop_data = {d1, d0};
        b0.rd_en = ren;  b0.rd_pos = {4'(p1), 4'(p0)};
        b1.clear = clr;  b1.drop_valid = dv;  b1.drop_data = {d1, d0};
        b1.rd_en = ren;  b1.rd_pos = {4'(p1), 4'(p0)};
    endtask

    task automatic clear_expect();
        model_q.delete();
        for (int p = 0; p < 2; p++) begin
            e0d[p] = 32'h0; e0v[p] = 1'b0; e1d[p] = 32'h0; e1v[p] = 1'b0;
        end
    endtask

    // One clock: drive at negedge, predict, clock, compare at the next negedge.
    task automatic step(input logic clr, input logic [1:0] dv, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [1:0] ren, input int p0, input int p1);
        int          pos [2];
        logic [31:0] dat [2];
        pos[0] = p0; pos[1] = p1; dat[0] = d0; dat[1] = d1;
        drive(clr, dv, d0, d1, ren, p0, p1);
        for (int p = 0; p < 2; p++)
            if (ren[p]) {e0v[p], e0d[p]} = model_read(pos[p]);
        if (clr) model_q.delete();
        for (int k = 0; k < 2; k++) begin
            if (dv[k]) begin
                model_q.push_front(dat[k]);
                if (model_q.size() > c_depth) void'(model_q.pop_back());
            end
        end
        for (int p = 0; p < 2; p++)
            if (ren[p]) {e1v[p], e1d[p]} = model_read(pos[p]);
        @(posedge clk);
        @(negedge clk);
        chk("b0_occ", 32'(b0.occ), 32'(model_q.size()));
        chk("b1_occ", 32'(b1.occ), 32'(model_q.size()));
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("b0_data%0d", p), b0.rd_data[p*32 +: 32], e0d[p]);
            chk($sformatf("b0_vld%0d", p), 32'(b0.rd_vld[p]), 32'(e0v[p]));
            chk($sformatf("b1_data%0d", p), b1.rd_data[p*32 +: 32], e1d[p]);
            chk($sformatf("b1_vld%0d", p), 32'(b1.rd_vld[p]), 32'(e1v[p]));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected values below are for the BYPASS=0 instance.
        tbl[0]  = '{1'b0, 2'b00, 32'h0,    32'h0,  2'b11, 0, 5, 0, 32'h0,  1'b0, 32'h0,  1'b0};
        tbl[1]  = '{1'b0, 2'b01, 32'h11,   32'h0,  2'b00, 0, 0, 1, 32'h0,  1'b0, 32'h0,  1'b0};
        tbl[2]  = '{1'b0, 2'b01, 32'h22,   32'h0,  2'b00, 0, 0, 2, 32'h0,  1'b0, 32'h0,  1'b0};
        tbl[3]  = '{1'b0, 2'b00, 32'h0,    32'h0,  2'b11, 0, 1, 2, 32'h22, 1'b1, 32'h11, 1'b1};
        tbl[4]  = '{1'b0, 2'b00, 32'h0,    32'h0,  2'b11, 2, 1, 2, 32'h0,  1'b0, 32'h11, 1'b1};
        tbl[5]  = '{1'b1, 2'b11, 32'hA,    32'hB,  2'b00, 0, 0, 2, 32'h0,  1'b0, 32'h11, 1'b1};
        tbl[6]  = '{1'b0, 2'b00, 32'h0,    32'h0,  2'b11, 0, 1, 2, 32'hB,  1'b1, 32'hA,  1'b1};
        tbl[7]  = '{1'b0, 2'b10, 32'hDEAD, 32'hC,  2'b00, 0, 0, 3, 32'hB,  1'b1, 32'hA,  1'b1};
        tbl[8]  = '{1'b0, 2'b00, 32'h0,    32'h0,  2'b11, 0, 2, 3, 32'hC,  1'b1, 32'hA,  1'b1};
        tbl[9]  = '{1'b1, 2'b00, 32'h0,    32'h0,  2'b01, 0, 0, 0, 32'hC,  1'b1, 32'hA,  1'b1};
        tbl[10] = '{1'b0, 2'b00, 32'h0,    32'h0,  2'b11, 0, 3, 0, 32'h0,  1'b0, 32'h0,  1'b0};

        clear_expect();
        rst_n = 1'b0;
        drive(1'b0, 2'b11, 32'h1234, 32'h5678, 2'b11, 0, 5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_occ0", 32'(b0.occ), 32'h0);
        chk("rst_occ1", 32'(b1.occ), 32'h0);
        chk("rst_vld0", 32'(b0.rd_vld), 32'h0);
        chk("rst_data0", b0.rd_data[31:0], 32'h0);
        chk("rst_data1", b1.rd_data[63:32], 32'h0);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].clr, tbl[i].dv, tbl[i].d0, tbl[i].d1, tbl[i].ren, tbl[i].p0, tbl[i].p1);
            chk($sformatf("tbl%0d_occ", i), 32'(b0.occ), 32'(tbl[i].eocc));
            chk($sformatf("tbl%0d_d0", i), b0.rd_data[31:0], tbl[i].ed0);
            chk($sformatf("tbl%0d_v0", i), 32'(b0.rd_vld[0]), 32'(tbl[i].ev0));
            chk($sformatf("tbl%0d_d1", i), b0.rd_data[63:32], tbl[i].ed1);
            chk($sformatf("tbl%0d_v1", i), 32'(b0.rd_vld[1]), 32'(tbl[i].ev1));
        end

        // Overflow: seventeen single drops into an empty belt.
        for (int i = 1; i <= 17; i++) step(1'b0, 2'b01, 32'(i), 32'h0, 2'b00, 0, 0);
        step(1'b0, 2'b00, 32'h0, 32'h0, 2'b11, 0, 15);
        chk("ovf_occ", 32'(b0.occ), 32'd16);
        chk("ovf_pos0", b0.rd_data[31:0], 32'd17);
        chk("ovf_pos15", b0.rd_data[63:32], 32'd2);

        // Same-edge drop and read of position 0.
        step(1'b0, 2'b01, 32'h44, 32'h0, 2'b00, 0, 0);
        step(1'b0, 2'b01, 32'h55, 32'h0, 2'b01, 0, 0);
        chk("byp0_pos0", b0.rd_data[31:0], 32'h44);
        chk("byp1_pos0", b1.rd_data[31:0], 32'h55);

        // Clear combined with a drop, then hold with reads disabled.
        step(1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 0, 0);
        for (int i = 1; i <= 5; i++) step(1'b0, 2'b01, 32'h100 + 32'(i), 32'h0, 2'b00, 0, 0);
        chk("occ5", 32'(b0.occ), 32'd5);
        step(1'b1, 2'b01, 32'h77, 32'h0, 2'b00, 0, 0);
        chk("clrdrop_occ", 32'(b0.occ), 32'd1);
        step(1'b0, 2'b00, 32'h0, 32'h0, 2'b11, 0, 1);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("hold%0d_d0", c), b0.rd_data[31:0], 32'h77);
            chk($sformatf("hold%0d_v0", c), 32'(b0.rd_vld[0]), 32'h1);
            chk($sformatf("hold%0d_d1", c), b1.rd_data[63:32], 32'h0);
            chk($sformatf("hold%0d_v1", c), 32'(b1.rd_vld[1]), 32'h0);
            if (c < 3) step(1'b0, 2'b11, 32'hEE, 32'hFF, 2'b00, 0, 0);
        end

        // Randomised traffic against the reference belt.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 24) == 0), 2'($urandom), $urandom, $urandom,
                 2'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        // Asynchronous reset in mid-cycle while drops are requested.
        drive(1'b0, 2'b11, 32'hAA, 32'hBB, 2'b11, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_occ_async", 32'(b0.occ), 32'h0);
        chk("arst_vld_async", 32'(b1.rd_vld), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("arst_occ_held", 32'(b0.occ), 32'h0);
        chk("arst_occ_held1", 32'(b1.occ), 32'h0);
        clear_expect();
        rst_n = 1'b1;
        step(1'b0, 2'b00, 32'h0, 32'h0, 2'b11, 0, 1);
        step(1'b0, 2'b01, 32'h99, 32'h0, 2'b01, 0, 0);
        step(1'b0, 2'b00, 32'h0, 32'h0, 2'b11, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/belt_mp.md
# belt_mp

Parametrised multi-port belt for the belt-machine CPU core. It replaces the fixed 16×32, 2-read, 1-drop belt with one that has configurable width, depth, read-port count and drops-per-cycle. It also tracks occupancy, so reads of never-dropped positions are flagged invalid, and supports a one-cycle clear for exception/flush. It sits between the decode/execute stages, which drop results, and the operand fetch, which reads belt positions.

## Interface
- `WIDTH`, 32, data width of one belt entry
- `DEPTH`, 16, number of entries; power of two, ≥4
- `RPORTS`, 2, number of independent read ports, ≥1
- `DROPS`, 2, maximum drops per cycle, 1..DEPTH
- `BYPASS`, 0, 0: reads see pre-drop state; 1: reads see post-drop state of the same edge
- Local `PW = clog2(DEPTH)`.

Ports:
- `clk` in 1: clock, rising edge
- `rst_n` in 1: reset; one clock, asynchronous assert, active-low; deassertion synchronised externally
- `clear` in 1: empty the belt (occupancy → 0)
- `drop_valid` in DROPS: per-slot drop request
- `drop_data` in DROPS*WIDTH: slot k occupies bits [k*WIDTH +: WIDTH]
- `rd_en` in RPORTS: per-port read enable
- `rd_pos` in RPORTS*PW: belt position per port; 0 = most recent drop
- `rd_data` out RPORTS*WIDTH: registered read data
- `rd_vld` out RPORTS: registered; position held a valid entry
- `occ` out PW+1: current number of valid entries, 0..DEPTH

## Operation
- State: write pointer `idx` (PW bits, wraps mod DEPTH), occupancy counter `occ`, storage array DEPTH×WIDTH. Storage is not reset.
- Position p maps to physical entry `(idx - 1 - p) mod DEPTH`.
- Drops:
  - n = popcount(drop_valid).
  - Set bits are taken in ascending slot order. The j-th set bit (j = 0..n-1) writes `idx + j`.
  - Then `idx += n` and `occ = min(occ + n, DEPTH)`.
  - The highest set slot becomes position 0.
  - Gaps in drop_valid are legal and ignored.
- Overflow: the oldest entry is silently overwritten, and occ stays at DEPTH. This is required belt semantics, not an error.
- Clear:
  - Sets occ to 0; idx is unchanged.
  - Clear and drops in the same cycle: clear applies first, then the drops, so occ = n.
- Read, per port p with rd_en[p]=1, at the clock edge:
  - `rd_vld[p] = rd_pos[p] < occ_view`.
  - `rd_data[p]` = the entry at rd_pos[p] if valid, else 0.
  - With BYPASS=0, occ_view, idx and contents are the pre-edge state.
  - With BYPASS=1 they are the state after this edge's clear and drops. Drop data is forwarded; the stale array is not read.
- Read with rd_en[p]=0: rd_data[p] and rd_vld[p] hold their values.
- Ports are fully independent; multiple ports may read the same position.

## Timing
- Reset (rst_n low, asynchronous): idx=0, occ=0, all rd_data=0, all rd_vld=0. Assertion mid-drop discards the drop.
- Read latency: 1 cycle. rd_pos sampled at edge N is reflected on rd_data/rd_vld after edge N.
- Drop latency: a value dropped at edge N is readable at position 0 by a read sampled at edge N+1 (BYPASS=0) or at edge N itself (BYPASS=1).
- occ is a registered output, updated at the same edge as the drop or clear.
- No backpressure: every drop is accepted every cycle.

## Structure
- Package `belt_pkg`:
  - `clog2` function
  - position type sized from DEPTH
  - popcount/prefix-count function used for slot → offset mapping
- Sub-module `belt_rport`: one read port covering position→address arithmetic, valid compare, bypass forwarding mux and the output register. Instantiated RPORTS times via generate.
- The top level holds storage, idx, occ, and the drop-offset prefix logic.

## Test plan
Default parameters (DEPTH=16, DROPS=2, RPORTS=2) unless noted.
- After reset, read pos 0 and 5 → rd_data=0, rd_vld=0, occ=0. Assert rst_n low while drop_valid=2'b11 → occ stays 0.
- Single drops of 0x11 then 0x22; read pos0/pos1 → 0x22/0x11, both vld, occ=2. Read pos2 → data 0, vld 0.
- Dual drop in one cycle, slot0=0xA, slot1=0xB → pos0=0xB, pos1=0xA, occ=2. Then drop_valid=2'b10 with slot1=0xC → pos0=0xC, occ=3.
- 17 single drops of values 1..17 → occ=16, pos0=17, pos15=2, idx wraps to 1.
- Drop 0x55 while reading pos0 on the same edge, with pos0 previously 0x44 → BYPASS=0 returns 0x44; BYPASS=1 returns 0x55.
- With occ=5: clear plus drop_valid=2'b01, slot0=0x77 → occ=1, pos0=0x77 vld, pos1 data 0 vld 0. Deassert rd_en → outputs hold for 3 cycles.
